image_loader: RTL and testbench

IMAGE_LOADER -- requirements
Module: image_loader

---
 rtl/image_loader.sv | 100 ++++++++++
 tb/tb_image_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/image_loader.sv
// image_loader: accepts a stream of grey-level bytes and writes one frame of
// IMG_PIXELS words into the frame RAM, one write per accepted byte, with the
// write appearing exactly one cycle after its acceptance.
module image_loader #(
    parameter int IMG_PIXELS = 65536,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] wr_address,
    output logic [31:0]       wr_data,
    output logic              wr_en,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Accepted-count value at which the byte being accepted is the last one.
    // The count is one bit wider than the address so completion never
    // depends on the address wrapping back to zero.
    localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W + 1)'(IMG_PIXELS - 1);

    state_t              state;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [ADDR_W:0]     acc_cnt;
    logic                accept;

    // Handshake and status flags decode straight from the state register, so
    // in_ready never looks at in_valid.
    assign in_ready = (state == LOAD);
    assign busy     = (state == LOAD) || (state == FLUSH);
    assign done     = (state == DONE);
    assign accept   = in_ready && in_valid;

    // Frame-load FSM, accept counters and the registered frame-RAM write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_cnt   <= {ADDR_W{1'b0}};
            acc_cnt    <= {(ADDR_W + 1){1'b0}};
            wr_en      <= 1'b0;
            wr_address <= {ADDR_W{1'b0}};
            wr_data    <= 32'd0;
        end else begin
            // A write strobe lasts exactly one cycle; address and data hold.
            wr_en <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // start wins over a simultaneous abort here; abort alone is ignored.
                    if (start) begin
                        state    <= LOAD;
                        addr_cnt <= {ADDR_W{1'b0}};
                        acc_cnt  <= {(ADDR_W + 1){1'b0}};
                    end else begin
                        state <= state;
                    end
                end
                LOAD: begin
                    // A byte accepted on the abort cycle still gets its write.
                    if (accept) begin
                        wr_en      <= 1'b1;
                        wr_address <= addr_cnt;
                        wr_data    <= {24'd0, in_data};
                        addr_cnt   <= addr_cnt + ADDR_W'(1);
                        acc_cnt    <= acc_cnt + (ADDR_W + 1)'(1);
                    end else begin
                        addr_cnt <= addr_cnt;
                    end
                    // abort beats both start (ignored in LOAD) and completion.
                    if (abort) begin
                        state <= IDLE;
                    end else if (accept && (acc_cnt == LAST_COUNT)) begin
                        state <= FLUSH;
                    end else begin
                        state <= LOAD;
                    end
                end
                FLUSH: begin
                    // The final write is visible during this cycle; no bytes taken.
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// tb_image_loader: directed self-checking bench for image_loader with the
// default 256 x 256 frame size.
module tb_image_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] wr_address;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        busy;
    logic        done;

    int pass_cnt;
    int total_cnt;

    image_loader #(
        .IMG_PIXELS(65536),
        .ADDR_W    (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .wr_address(wr_address),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; inputs set before the call are sampled at this edge,
    // outputs read after the call are the post-edge values.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; abort = 1'b0; in_valid = 1'b1; in_data = 8'h55;
        tick();
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else pass_cnt++;
        total_cnt++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", wr_en); else pass_cnt++;
        total_cnt++; if (wr_address !== 16'h0000) $display("FAIL reset_wr_address got %h want 0000", wr_address); else pass_cnt++;
        total_cnt++; if (wr_data !== 32'h0) $display("FAIL reset_wr_data got %h want 0", wr_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_status got busy=%b done=%b want 0 0", busy, done); else pass_cnt++;
        // abort alone in IDLE does nothing
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total_cnt++; if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL idle_abort got busy=%b in_ready=%b want 0 0", busy, in_ready); else pass_cnt++;
    endtask

    task automatic test_full_load();
        int errs;
        errs = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++; if (busy !== 1'b1 || in_ready !== 1'b1 || wr_en !== 1'b0) $display("FAIL full_start got busy=%b in_ready=%b wr_en=%b want 1 1 0", busy, in_ready, wr_en); else pass_cnt++;
        for (int i = 0; i < 65536; i++) begin
            in_valid = 1'b1;
            in_data  = i[7:0];
            tick();
            if (wr_en !== 1'b1 || wr_address !== 16'(i) || wr_data !== {24'd0, i[7:0]} || busy !== 1'b1) begin
                if (errs < 5) $display("FAIL full_write idx %0d got en=%b addr=%h data=%h busy=%b", i, wr_en, wr_address, wr_data, busy);
                errs++;
            end
            if (i < 65535 && in_ready !== 1'b1) errs++;
        end
        in_valid = 1'b0;
        total_cnt++; if (errs !== 0) $display("FAIL full_sequence got %0d errors want 0", errs); else pass_cnt++;
        // FLUSH cycle: final write visible, no more acceptance, not yet done
        total_cnt++; if (in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b1) $display("FAIL full_flush got in_ready=%b done=%b busy=%b want 0 0 1", in_ready, done, busy); else pass_cnt++;
        tick();
        total_cnt++; if (done !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) $display("FAIL full_done got done=%b busy=%b wr_en=%b want 1 0 0", done, busy, wr_en); else pass_cnt++;
        total_cnt++; if (wr_address !== 16'hFFFF || wr_data !== 32'h000000FF) $display("FAIL full_hold got addr=%h data=%h want ffff 000000ff", wr_address, wr_data); else pass_cnt++;
        // abort in DONE is ignored and done stays high
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        total_cnt++; if (done !== 1'b1) $display("FAIL done_abort got done=%b want 1", done); else pass_cnt++;
    endtask

    task automatic test_start_from_done();
        start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++; if (done !== 1'b0 || busy !== 1'b1 || wr_en !== 1'b0) $display("FAIL restart_status got done=%b busy=%b wr_en=%b want 0 1 0", done, busy, wr_en); else pass_cnt++;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        total_cnt++; if (wr_en !== 1'b1 || wr_address !== 16'h0000 || wr_data !== 32'h000000A5) $display("FAIL restart_first got en=%b addr=%h data=%h want 1 0000 000000a5", wr_en, wr_address, wr_data); else pass_cnt++;
    endtask

    // Continues the load begun in test_start_from_done; start pulses at byte 500.
    task automatic test_mid_start();
        int errs;
        errs = 0;
        for (int i = 1; i < 600; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i * 3);
            start    = (i == 500);
            tick();
            if (wr_en !== 1'b1 || wr_address !== 16'(i) || wr_data !== {24'd0, 8'(i * 3)}) begin
                if (errs < 5) $display("FAIL mid_start idx %0d got en=%b addr=%h data=%h", i, wr_en, wr_address, wr_data);
                errs++;
            end
        end
        start = 1'b0;
        total_cnt++; if (errs !== 0) $display("FAIL mid_start_sequence got %0d errors want 0", errs); else pass_cnt++;
        // start and abort together in LOAD: abort wins
        in_valid = 1'b0;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        total_cnt++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0) $display("FAIL load_start_abort got busy=%b in_ready=%b done=%b wr_en=%b want 0 0 0 0", busy, in_ready, done, wr_en); else pass_cnt++;
    endtask

    task automatic test_abort();
        int writes;
        logic [15:0] last_addr;
        writes = 0;
        last_addr = 16'h0000;
        // start and abort together in IDLE: start wins
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL idle_start_abort got busy=%b want 1", busy); else pass_cnt++;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
            if (wr_en === 1'b1) begin writes++; last_addr = wr_address; end
        end
        in_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        if (wr_en === 1'b1) writes++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wr_en === 1'b1) writes++;
        end
        total_cnt++; if (writes !== 100 || last_addr !== 16'd99) $display("FAIL abort_writes got %0d last=%0d want 100 99", writes, last_addr); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) $display("FAIL abort_state got busy=%b done=%b in_ready=%b want 0 0 0", busy, done, in_ready); else pass_cnt++;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h07;
        tick();
        total_cnt++; if (wr_en !== 1'b1 || wr_address !== 16'h0000 || wr_data !== 32'h7) $display("FAIL abort_restart got en=%b addr=%h data=%h want 1 0000 00000007", wr_en, wr_address, wr_data); else pass_cnt++;
        // accept on the abort cycle itself: that write still completes
        in_data = 8'h3C; abort = 1'b1;
        tick();
        abort = 1'b0; in_valid = 1'b0;
        total_cnt++; if (wr_en !== 1'b1 || wr_address !== 16'h0001 || wr_data !== 32'h3C || busy !== 1'b0) $display("FAIL abort_cycle_write got en=%b addr=%h data=%h busy=%b want 1 0001 0000003c 0", wr_en, wr_address, wr_data, busy); else pass_cnt++;
        tick();
        total_cnt++; if (wr_en !== 1'b0 || in_ready !== 1'b0) $display("FAIL abort_after got wr_en=%b in_ready=%b want 0 0", wr_en, in_ready); else pass_cnt++;
    endtask

    task automatic test_gaps();
        int errs;
        int acc;
        logic v;
        errs = 0;
        acc  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            v = ((k % 3) != 1) && ((k % 7) != 4);
            in_valid = v;
            in_data  = 8'(k ^ 8'h5A);
            tick();
            if (v) begin
                if (wr_en !== 1'b1 || wr_address !== 16'(acc) || wr_data !== {24'd0, 8'(k ^ 8'h5A)}) errs++;
                acc++;
            end else begin
                if (wr_en !== 1'b0 || (acc > 0 && wr_address !== 16'(acc - 1))) errs++;
            end
        end
        in_valid = 1'b0;
        total_cnt++; if (errs !== 0) $display("FAIL gaps_sequence got %0d errors want 0", errs); else pass_cnt++;
        tick();
        total_cnt++; if (wr_en !== 1'b0 || in_ready !== 1'b1) $display("FAIL gaps_idle_cycle got wr_en=%b in_ready=%b want 0 1", wr_en, in_ready); else pass_cnt++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
        end
        total_cnt++; if (wr_en !== 1'b1 || wr_address !== 16'd999) $display("FAIL pre_reset_write got en=%b addr=%0d want 1 999", wr_en, wr_address); else pass_cnt++;
        reset = 1'b1; start = 1'b1; abort = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        total_cnt++; if (wr_en !== 1'b0) $display("FAIL reset_mid_wr_en got %b want 0", wr_en); else pass_cnt++;
        total_cnt++; if (wr_address !== 16'h0 || wr_data !== 32'h0) $display("FAIL reset_mid_port got addr=%h data=%h want 0000 0", wr_address, wr_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) $display("FAIL reset_mid_status got busy=%b done=%b in_ready=%b want 0 0 0", busy, done, in_ready); else pass_cnt++;
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        tick();
        test_reset();
        test_full_load();
        test_start_from_done();
        test_mid_start();
        test_abort();
        test_gaps();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
